// File: rtl/mul_operand_feeder.sv
// Operand feeder for a shift-add multiplier controller: buffers {a,b} pairs in a
// 2-deep FIFO, sequences each pair onto the core and returns product or error code.
module mul_operand_feeder #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_lda,
  input  logic         mul_ldb,
  input  logic         mul_done,
  input  logic [W-1:0] mul_prod,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic [1:0]   out_err
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    START,
    LOAD_A,
    LOAD_B,
    RUN,
    RESP
  } state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  localparam logic [1:0]   ERR_OK      = 2'b00;
  localparam logic [1:0]   ERR_ODD     = 2'b01;
  localparam logic [1:0]   ERR_TIMEOUT = 2'b10;
  localparam logic [W-1:0] LAST        = W'(TIMEOUT - 1);

  state_t       state;
  logic [W-1:0] wa;
  logic [W-1:0] wb;
  logic [W-1:0] cnt;

  // ---------------------------------------------------------------------------
  // Two-entry pair FIFO
  // ---------------------------------------------------------------------------
  pair_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  pair_t      head;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  // Held low while reset is asserted so no pair is accepted into a FIFO being cleared.
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  // CHECK is only entered with a non-empty FIFO, so the pop never underflows.
  assign pop      = (state == CHECK);
  assign head     = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wa        <= '0;
      wb        <= '0;
      cnt       <= '0;
      mul_start <= 1'b0;
      mul_data  <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_err   <= ERR_OK;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) state <= CHECK;
        end

        CHECK: begin
          wa <= head.a;
          wb <= head.b;
          // The core only terminates for an even multiplier count.
          if (head.b[0]) begin
            state     <= RESP;
            out_valid <= 1'b1;
            out_prod  <= '0;
            out_err   <= ERR_ODD;
          end else begin
            state     <= START;
            mul_start <= 1'b1;
            mul_data  <= head.a;
          end
        end

        START: begin
          state    <= LOAD_A;
          cnt      <= '0;
          mul_data <= wa;
        end

        LOAD_A, LOAD_B, RUN: begin
          cnt <= cnt + 1'b1;
          if (state == LOAD_A && mul_lda) begin
            state    <= LOAD_B;
            mul_data <= wb;
          end else if (state == LOAD_B && mul_ldb) begin
            state <= RUN;
          end else if (state == RUN && mul_done) begin
            state     <= RESP;
            mul_data  <= '0;
            out_valid <= 1'b1;
            out_prod  <= mul_prod;
            out_err   <= ERR_OK;
          end else if (cnt == LAST) begin
            // Budget covers the whole load-and-run window, not just RUN.
            state     <= RESP;
            mul_data  <= '0;
            out_valid <= 1'b1;
            out_prod  <= '0;
            out_err   <= ERR_TIMEOUT;
          end
        end

        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Self-checking bench for mul_operand_feeder: directed and random pairs against a
// queue-based result model, with a stand-in multiplier core of random latency.
module tb_mul_operand_feeder;
  localparam int W  = 16;
  localparam int TO = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         mul_start;
  logic [W-1:0] mul_data;
  logic         mul_lda;
  logic         mul_ldb;
  logic         mul_done;
  logic [W-1:0] mul_prod;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic [1:0]   out_err;

  mul_operand_feeder #(.W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_data  (mul_data),
    .mul_lda   (mul_lda),
    .mul_ldb   (mul_ldb),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] prod;
    logic [1:0]   err;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   exp_starts = 0;
  int   start_cnt  = 0;
  bit   core_hang  = 1'b0;

  // Stand-in multiplier controller; acts just after each rising edge.
  initial begin : core
    int           phase;
    int           wait_n;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    phase    = 0;
    wait_n   = 0;
    core_a   = '0;
    core_b   = '0;
    mul_lda  = 1'b0;
    mul_ldb  = 1'b0;
    mul_done = 1'b0;
    mul_prod = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_lda  = 1'b0;
      mul_ldb  = 1'b0;
      mul_done = 1'b0;
      mul_prod = W'($urandom);
      if (!rst_n) begin
        phase = 0;
      end else if (mul_start) begin
        start_cnt++;
        phase  = 1;
        wait_n = $urandom_range(1, 3);
      end else begin
        case (phase)
          1: begin
            wait_n--;
            if (wait_n == 0) begin
              mul_lda = 1'b1;
              core_a  = mul_data;
              phase   = 2;
              wait_n  = $urandom_range(1, 3);
            end
          end
          2: begin
            wait_n--;
            if (wait_n == 0) begin
              mul_ldb = 1'b1;
              core_b  = mul_data;
              phase   = 3;
              wait_n  = $urandom_range(1, 4);
            end
          end
          3: begin
            if (!core_hang) begin
              wait_n--;
              if (wait_n == 0) begin
                mul_done = 1'b1;
                mul_prod = W'(core_a * core_b);
                phase    = 0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result model: odd B rejected, hung core times out, otherwise product mod 2^W.
  function automatic void model_add(input logic [W-1:0] a, input logic [W-1:0] b, input bit hang);
    exp_t   e;
    longint prod_full;
    if (b[0]) begin
      e.prod = '0;
      e.err  = 2'b01;
    end else if (hang) begin
      e.prod = '0;
      e.err  = 2'b10;
      exp_starts++;
    end else begin
      prod_full = longint'(a) * longint'(b);
      e.prod    = W'(prod_full % (longint'(1) << W));
      e.err     = 2'b00;
      exp_starts++;
    end
    exp_q.push_back(e);
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int stalls);
    int guard;
    guard    = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    stalls = guard;
    chk("push_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    while (!mul_start && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("mul_start_wait", 32'(mul_start), 32'd1);
  endtask

  task automatic get_result(input int stall, input string tag);
    exp_t e;
    e = exp_q.pop_front();
    wait_valid();
    chk({tag, "_prod"}, 32'(out_prod), 32'(e.prod));
    chk({tag, "_err"}, 32'(out_err), 32'(e.err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_prod"}, 32'(out_prod), 32'(e.prod));
      chk({tag, "_hold_err"}, 32'(out_err), 32'(e.err));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin : stim
    int           st;
    int           n;
    int           s0;
    int           guard;
    logic [W-1:0] ra [3];
    logic [W-1:0] rb [3];
    logic [W-1:0] xa;
    logic [W-1:0] xb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_data", 32'(mul_data), 32'd0);
    chk("rst_out_prod", 32'(out_prod), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 7 x 6: three-cycle launch latency, mul_data sequence, product 42
    s0 = start_cnt;
    model_add(16'd7, 16'd6, 1'b0);
    in_a     = 16'd7;
    in_b     = 16'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_c1_start", 32'(mul_start), 32'd0);
    @(negedge clk);
    chk("lat_c2_start", 32'(mul_start), 32'd0);
    chk("lat_c2_data", 32'(mul_data), 32'd0);
    @(negedge clk);
    chk("lat_c3_start", 32'(mul_start), 32'd1);
    chk("start_data_a", 32'(mul_data), 32'd7);
    @(negedge clk);
    chk("start_one_cycle", 32'(mul_start), 32'd0);
    chk("loada_data_a", 32'(mul_data), 32'd7);
    guard = 0;
    while (mul_data === 16'd7 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("loadb_data_b", 32'(mul_data), 32'd6);
    get_result(0, "p7x6");
    chk("p7x6_prod_42", 32'(out_prod), 32'd42);
    chk("idle_mul_data", 32'(mul_data), 32'd0);
    chk("p7x6_starts", 32'(start_cnt - s0), 32'd1);

    // 5 x 3: odd B rejected without launching the core
    s0 = start_cnt;
    model_add(16'd5, 16'd3, 1'b0);
    push(16'd5, 16'd3, st);
    get_result(0, "odd");
    chk("odd_no_start", 32'(start_cnt - s0), 32'd0);

    // B = 0 launched normally; wrap-around product
    model_add(16'd1234, 16'd0, 1'b0);
    push(16'd1234, 16'd0, st);
    get_result(0, "bzero");
    model_add(16'hFFFF, 16'hFFFE, 1'b0);
    push(16'hFFFF, 16'hFFFE, st);
    get_result(1, "wrap");

    // Push accepted while in RESP; then 5-cycle output stall
    model_add(16'd9, 16'd4, 1'b0);
    push(16'd9, 16'd4, st);
    wait_valid();
    chk("resp_in_ready", 32'(in_ready), 32'd1);
    model_add(16'd10, 16'd2, 1'b0);
    push(16'd10, 16'd2, st);
    chk("resp_push_nostall", 32'(st), 32'd0);
    chk("resp_still_valid", 32'(out_valid), 32'd1);
    get_result(5, "stall");
    get_result(0, "after_resp");

    // Three back-to-back pairs with downstream stalled
    for (int i = 0; i < 3; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
    end
    rb[0][0] = 1'b0;
    rb[1][0] = 1'b1;
    rb[2][0] = 1'b0;
    for (int i = 0; i < 3; i++) model_add(ra[i], rb[i], 1'b0);
    push(ra[0], rb[0], st);
    push(ra[1], rb[1], st);
    chk("b2b_p2_nostall", 32'(st), 32'd0);
    push(ra[2], rb[2], st);
    chk("b2b_p3_stalled", 32'(st > 0), 32'd1);
    repeat (4) @(negedge clk);
    get_result(2, "b2b0");
    get_result(0, "b2b1");
    get_result(1, "b2b2");

    // Random pairs
    for (int i = 0; i < 10; i++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      xb[0] = ($urandom_range(0, 3) == 0);
      model_add(xa, xb, 1'b0);
      push(xa, xb, st);
      get_result($urandom_range(0, 2), "rand");
    end

    // Timeout: core never finishes; error appears 16 cycles after LOAD_A entry
    core_hang = 1'b1;
    model_add(16'd3, 16'd8, 1'b1);
    push(16'd3, 16'd8, st);
    wait_start();
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd17);
    get_result(0, "timeout");
    core_hang = 1'b0;

    // Reset during RUN with a second pair queued
    core_hang = 1'b1;
    push(16'd11, 16'd6, st);
    exp_starts++;
    wait_start();
    repeat (8) @(negedge clk);
    push(16'd13, 16'd2, st);
    s0    = start_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_mul_data", 32'(mul_data), 32'd0);
    rst_n     = 1'b1;
    core_hang = 1'b0;
    @(negedge clk);
    chk("midrst_rel_ready", 32'(in_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst_no_output", 32'(n), 32'd0);
    chk("midrst_no_launch", 32'(start_cnt - s0), 32'd0);
    model_add(16'd2, 16'd4, 1'b0);
    push(16'd2, 16'd4, st);
    get_result(0, "post_rst");
    chk("post_rst_prod_8", 32'(out_prod), 32'd8);

    chk("start_total", 32'(start_cnt), 32'(exp_starts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
